// File: rtl/dmem_axi_lite_master.sv
// Data-side AXI4-Lite master for the MEM stage. Each load/store request becomes exactly
// one AXI-Lite read or write; the pipeline is stalled until the response returns, then
// the read word and an error flag are presented for one cycle.
module dmem_axi_lite_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // MEM-stage request / response
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic [DATA_W/8-1:0]   req_wstrb_i,
  output logic                  stall_o,
  output logic                  resp_valid_o,
  output logic [DATA_W-1:0]     resp_rdata_o,
  output logic                  resp_err_o,
  // AW channel
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  // W channel
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  // B channel
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  // AR channel
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  // R channel
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t              state, state_nxt;

  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic [STRB_W-1:0]   wstrb_q, wstrb_nxt;

  logic                arvalid_q, arvalid_nxt;
  logic                awvalid_q, awvalid_nxt;
  logic                wvalid_q, wvalid_nxt;
  logic                bready_q, bready_nxt;
  logic                rready_q, rready_nxt;
  logic                aw_done_q, aw_done_nxt;
  logic                w_done_q, w_done_nxt;

  logic                resp_valid_q, resp_valid_nxt;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_nxt;
  logic                resp_err_q, resp_err_nxt;

  logic                ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic                aw_all, w_all;

  // Channel handshakes; valids are registered and never derived from ready
  assign ar_hs  = arvalid_q & m_arready;
  assign r_hs   = rready_q  & m_rvalid;
  assign aw_hs  = awvalid_q & m_awready;
  assign w_hs   = wvalid_q  & m_wready;
  assign b_hs   = bready_q  & m_bvalid;
  assign aw_all = aw_done_q | aw_hs;
  assign w_all  = w_done_q  | w_hs;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      addr_q       <= addr_nxt;
      wdata_q      <= wdata_nxt;
      wstrb_q      <= wstrb_nxt;
      arvalid_q    <= arvalid_nxt;
      awvalid_q    <= awvalid_nxt;
      wvalid_q     <= wvalid_nxt;
      bready_q     <= bready_nxt;
      rready_q     <= rready_nxt;
      aw_done_q    <= aw_done_nxt;
      w_done_q     <= w_done_nxt;
      resp_valid_q <= resp_valid_nxt;
      resp_rdata_q <= resp_rdata_nxt;
      resp_err_q   <= resp_err_nxt;
    end
  end

  // Next-state and next-output logic; resp_valid is set only on entry to DONE
  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr_q;
    wdata_nxt      = wdata_q;
    wstrb_nxt      = wstrb_q;
    arvalid_nxt    = arvalid_q;
    awvalid_nxt    = awvalid_q;
    wvalid_nxt     = wvalid_q;
    bready_nxt     = bready_q;
    rready_nxt     = rready_q;
    aw_done_nxt    = aw_done_q;
    w_done_nxt     = w_done_q;
    resp_valid_nxt = 1'b0;
    resp_rdata_nxt = resp_rdata_q;
    resp_err_nxt   = resp_err_q;

    unique case (state)
      IDLE: begin
        if (req_valid_i) begin
          addr_nxt    = {req_addr_i[ADDR_W-1:2], 2'b00};
          wdata_nxt   = req_wdata_i;
          wstrb_nxt   = req_wstrb_i;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          if (req_we_i) begin
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WR_REQ;
          end else begin
            arvalid_nxt = 1'b1;
            state_nxt   = RD_ADDR;
          end
        end
      end

      RD_ADDR: begin
        if (ar_hs) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (r_hs) begin
          resp_rdata_nxt = m_rdata;
          resp_err_nxt   = m_rresp[1];
          rready_nxt     = 1'b0;
          resp_valid_nxt = 1'b1;
          state_nxt      = DONE;
        end
      end

      WR_REQ: begin
        // AW and W complete independently, possibly in the same cycle
        if (aw_hs) begin
          awvalid_nxt = 1'b0;
          aw_done_nxt = 1'b1;
        end
        if (w_hs) begin
          wvalid_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
        if (aw_all && w_all) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (b_hs) begin
          resp_err_nxt   = m_bresp[1];
          bready_nxt     = 1'b0;
          resp_valid_nxt = 1'b1;
          state_nxt      = DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stall releases in DONE so the MEM stage advances with the response
  assign stall_o = req_valid_i & (state != DONE);

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

  assign m_awaddr  = addr_q;
  assign m_awprot  = 3'b000;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_araddr  = addr_q;
  assign m_arprot  = 3'b000;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

  // Byte offset and the OKAY/EXOKAY distinction carry no information for this master
  logic unused_bits;
  assign unused_bits = ^{req_addr_i[1:0], m_rresp[0], m_bresp[0]};

endmodule

// File: tb/tb_dmem_axi_lite_master.sv
// Randomized scoreboard bench for dmem_axi_lite_master with a behavioural AXI-Lite slave.
`timescale 1ns/1ps
module tb_dmem_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        stall, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;

  always #5 clk = ~clk;

  dmem_axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .stall_o(stall), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ar_q[$];
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] ref_last = 32'h0;

  // Addresses in page 0x3Fxx are answered with SLVERR/DECERR by the slave
  function automatic logic is_err(input logic [31:0] a);
    return a[15:8] == 8'h3F;
  endfunction

  task automatic ref_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb);
    logic [31:0] w, cur;
    exp_t e;
    w = addr & 32'hFFFF_FFFC;
    e.we  = we;
    e.err = is_err(w);
    if (!we) begin
      ar_q.push_back(w);
      if (e.err) ref_last = ~w;
      else       ref_last = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    end else begin
      aw_q.push_back(w);
      w_q.push_back({strb, wdata});
      if (!e.err) begin
        cur = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[w] = cur;
      end
    end
    e.rdata = ref_last;
    sb_q.push_back(e);
  endtask

  // ---------------- behavioural AXI-Lite slave ----------------
  logic [31:0] smem[logic [31:0]];
  int ar_force = -1, r_force = -1, aw_force = -1, w_force = -1, b_force = -1, resp_lo = -1;

  // handshake observations, taken on the falling edge by the monitor
  bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [31:0] hs_araddr, hs_awaddr, hs_wdata;
  logic [3:0]  hs_wstrb;

  function automatic int pick(input int f);
    return (f >= 0) ? f : int'($urandom_range(0, 3));
  endfunction

  function automatic logic lo_bit();
    return (resp_lo >= 0) ? resp_lo[0] : 1'($urandom_range(0, 1));
  endfunction

  initial begin
    bit ar_act, aw_act, w_act, r_pend, b_pend, aw_got, w_got;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    logic [31:0] r_addr, s_awaddr, s_wdata, cur;
    logic [3:0]  s_wstrb;
    ar_act = 0; aw_act = 0; w_act = 0; r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    r_addr = 0; s_awaddr = 0; s_wdata = 0; s_wstrb = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        ar_act = 0; aw_act = 0; w_act = 0; r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      end else begin
        if (r_hs) m_rvalid = 0;
        if (b_hs) m_bvalid = 0;
        if (ar_hs) begin r_pend = 1; r_addr = hs_araddr; r_cnt = pick(r_force); ar_act = 0; end
        if (aw_hs) begin aw_got = 1; s_awaddr = hs_awaddr; aw_act = 0; end
        if (w_hs)  begin w_got = 1; s_wdata = hs_wdata; s_wstrb = hs_wstrb; w_act = 0; end
        if (aw_got && w_got) begin
          if (!is_err(s_awaddr)) begin
            cur = smem.exists(s_awaddr) ? smem[s_awaddr] : 32'h0;
            for (int b = 0; b < 4; b++) if (s_wstrb[b]) cur[8*b +: 8] = s_wdata[8*b +: 8];
            smem[s_awaddr] = cur;
          end
          b_pend = 1; b_cnt = pick(b_force); aw_got = 0; w_got = 0;
        end
        if (r_pend && !m_rvalid) begin
          if (r_cnt == 0) begin
            m_rvalid = 1;
            if (is_err(r_addr)) begin m_rdata = ~r_addr; m_rresp = {1'b1, lo_bit()}; end
            else begin m_rdata = smem.exists(r_addr) ? smem[r_addr] : 32'h0; m_rresp = {1'b0, lo_bit()}; end
            r_pend = 0;
          end else r_cnt--;
        end
        if (b_pend && !m_bvalid) begin
          if (b_cnt == 0) begin
            m_bvalid = 1;
            m_bresp  = {is_err(s_awaddr), lo_bit()};
            b_pend   = 0;
          end else b_cnt--;
        end
        if (m_arvalid && !ar_act) begin ar_act = 1; ar_cnt = pick(ar_force); end
        if (m_arvalid) begin
          if (ar_cnt == 0) m_arready = 1; else begin m_arready = 0; ar_cnt--; end
        end else m_arready = 0;
        if (m_awvalid && !aw_act) begin aw_act = 1; aw_cnt = pick(aw_force); end
        if (m_awvalid) begin
          if (aw_cnt == 0) m_awready = 1; else begin m_awready = 0; aw_cnt--; end
        end else m_awready = 0;
        if (m_wvalid && !w_act) begin w_act = 1; w_cnt = pick(w_force); end
        if (m_wvalid) begin
          if (w_cnt == 0) m_wready = 1; else begin m_wready = 0; w_cnt--; end
        end else m_wready = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit pv_ar, pr_ar, pv_aw, pr_aw, pv_w, pr_w;
    logic [31:0] p_araddr, p_awaddr;
    logic [35:0] p_w;
    exp_t e;
    pv_ar = 0; pr_ar = 0; pv_aw = 0; pr_aw = 0; pv_w = 0; pr_w = 0;
    p_araddr = 0; p_awaddr = 0; p_w = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        pv_ar = 0; pv_aw = 0; pv_w = 0;
      end else begin
        check("stall", 64'(stall), 64'(req_valid & ~resp_valid));
        if (resp_valid) begin
          if (sb_q.size() == 0) fail_now("resp_unexpected", "response with nothing outstanding");
          else begin
            e = sb_q.pop_front();
            check("resp_err", 64'(resp_err), 64'(e.err));
            check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
          end
        end
        if (pv_ar && !pr_ar) begin
          check("arvalid_held", 64'(m_arvalid), 64'(1));
          check("araddr_stable", 64'(m_araddr), 64'(p_araddr));
        end
        if (pv_aw && !pr_aw) begin
          check("awvalid_held", 64'(m_awvalid), 64'(1));
          check("awaddr_stable", 64'(m_awaddr), 64'(p_awaddr));
        end
        if (pv_w && !pr_w) begin
          check("wvalid_held", 64'(m_wvalid), 64'(1));
          check("wpayload_stable", 64'({m_wstrb, m_wdata}), 64'(p_w));
        end
        ar_hs = m_arvalid & m_arready;
        aw_hs = m_awvalid & m_awready;
        w_hs  = m_wvalid & m_wready;
        r_hs  = m_rvalid & m_rready;
        b_hs  = m_bvalid & m_bready;
        hs_araddr = m_araddr; hs_awaddr = m_awaddr; hs_wdata = m_wdata; hs_wstrb = m_wstrb;
        if (ar_hs) begin
          check("arprot", 64'(m_arprot), 64'(0));
          if (ar_q.size() == 0) fail_now("ar_unexpected", "AR handshake with no load outstanding");
          else check("araddr", 64'(m_araddr), 64'(ar_q.pop_front()));
        end
        if (aw_hs) begin
          check("awprot", 64'(m_awprot), 64'(0));
          if (aw_q.size() == 0) fail_now("aw_unexpected", "AW handshake with no store outstanding");
          else check("awaddr", 64'(m_awaddr), 64'(aw_q.pop_front()));
        end
        if (w_hs) begin
          if (w_q.size() == 0) fail_now("w_unexpected", "W handshake with no store outstanding");
          else check("wstrb_wdata", 64'({m_wstrb, m_wdata}), 64'(w_q.pop_front()));
        end
        pv_ar = m_arvalid; pr_ar = m_arready; p_araddr = m_araddr;
        pv_aw = m_awvalid; pr_aw = m_awready; p_awaddr = m_awaddr;
        pv_w  = m_wvalid;  pr_w  = m_wready;  p_w = {m_wstrb, m_wdata};
      end
    end
  end

  // ---------------- driver ----------------
  // Called on posedge+1; returns on posedge+1 of the IDLE cycle after DONE.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input bit drop,
                        output int first_v, output int ar_c, output int aw_c, output int w_c,
                        output int first_b, output int resp_c);
    ref_issue(we, addr, wdata, strb);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    first_v = -1; ar_c = 0; aw_c = 0; w_c = 0; first_b = -1; resp_c = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if ((we ? m_awvalid : m_arvalid) && first_v < 0) first_v = c;
      if (m_arvalid) ar_c++;
      if (m_awvalid) aw_c++;
      if (m_wvalid)  w_c++;
      if (m_bready && first_b < 0) first_b = c;
      if (resp_valid) begin resp_c = c; break; end
      @(posedge clk); #1;
      if (drop && c == 1) req_valid = 0;
    end
    if (resp_c < 0) fail_now("resp_timeout", "no resp_valid within 60 cycles");
    check("valid_issue_cycle", 64'(first_v), 64'(1));
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic set_force(input int v);
    ar_force = v; r_force = v; aw_force = v; w_force = v; b_force = v;
  endtask

  initial begin
    int fv, arc, awc, wc, fb, rc, gap;
    logic we;
    logic [31:0] a;
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // reset values
    @(negedge clk);
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_rdata", 64'(resp_rdata), 64'(0));
    check("rst_resp_err", 64'(resp_err), 64'(0));
    check("rst_valids", 64'({m_arvalid, m_awvalid, m_wvalid}), 64'(0));
    check("rst_readies", 64'({m_bready, m_rready}), 64'(0));
    @(posedge clk); #1;

    // zero-wait load: response on cycle 3, stall cycles 0-2
    set_force(0);
    smem[32'h1000] = 32'hDEAD_BEEF;
    ref_mem[32'h1000] = 32'hDEAD_BEEF;
    do_req(1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, fv, arc, awc, wc, fb, rc);
    check("load_latency", 64'(rc), 64'(3));

    // zero-wait store: same latency
    do_req(1'b1, 32'h1010, 32'hCAFE_F00D, 4'hF, 1'b0, fv, arc, awc, wc, fb, rc);
    check("store_latency", 64'(rc), 64'(3));

    // AW stalls 2 cycles, W accepted at once; B ready only once both are done
    aw_force = 2;
    do_req(1'b1, 32'h2004, 32'h1234_5678, 4'b0011, 1'b0, fv, arc, awc, wc, fb, rc);
    check("awvalid_cycles", 64'(awc), 64'(3));
    check("wvalid_cycles", 64'(wc), 64'(1));
    check("bready_first", 64'(fb), 64'(4));
    check("split_store_latency", 64'(rc), 64'(5));
    aw_force = 0;

    // misaligned addresses are word-aligned on the bus
    do_req(1'b0, 32'h1003, 32'h0, 4'h0, 1'b0, fv, arc, awc, wc, fb, rc);
    do_req(1'b1, 32'h2006, 32'hA5A5_5A5A, 4'b1100, 1'b0, fv, arc, awc, wc, fb, rc);
    // zero strobe store still goes out
    do_req(1'b1, 32'h2008, 32'hFFFF_FFFF, 4'b0000, 1'b0, fv, arc, awc, wc, fb, rc);

    // error responses: RRESP=10, BRESP=11
    resp_lo = 0;
    do_req(1'b0, 32'h3F10, 32'h0, 4'h0, 1'b0, fv, arc, awc, wc, fb, rc);
    resp_lo = 1;
    do_req(1'b1, 32'h3F20, 32'h1111_2222, 4'hF, 1'b0, fv, arc, awc, wc, fb, rc);
    resp_lo = -1;

    // back-to-back load (AR held off 5 cycles) then store
    ar_force = 5;
    do_req(1'b0, 32'h2004, 32'h0, 4'h0, 1'b0, fv, arc, awc, wc, fb, rc);
    check("b2b_arvalid_cycles", 64'(arc), 64'(6));
    check("b2b_load_latency", 64'(rc), 64'(8));
    ar_force = 0;
    do_req(1'b1, 32'h2000, 32'h0BAD_F00D, 4'b1001, 1'b0, fv, arc, awc, wc, fb, rc);
    check("b2b_store_latency", 64'(rc), 64'(3));

    // reset while waiting in RD_DATA
    r_force = 6;
    ref_issue(1'b0, 32'h1000, 32'h0, 4'h0);
    req_valid = 1; req_we = 0; req_addr = 32'h1000;
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (m_rready) seen = 1;
        else begin @(posedge clk); #1; end
      end
      if (!seen) fail_now("rd_data_timeout", "m_rready never rose");
    end
    @(posedge clk); #1;
    rst = 1; req_valid = 0;
    sb_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete();
    ref_last = 32'h0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rst_mid_rready", 64'(m_rready), 64'(0));
    check("rst_mid_arvalid", 64'(m_arvalid), 64'(0));
    check("rst_mid_rdata", 64'(resp_rdata), 64'(0));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("rst_no_resp", 64'(resp_valid), 64'(0));
    end
    @(posedge clk); #1;
    set_force(-1);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 32'h3F00 + 32'($urandom_range(0, 31));
      else                           a = 32'h1000 + 32'($urandom_range(0, 63));
      do_req(we, a, $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
             fv, arc, awc, wc, fb, rc);
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    check("ar_drained", 64'(ar_q.size()), 64'(0));
    check("aw_drained", 64'(aw_q.size() + w_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
